// File: rtl/z_pkg.sv
// Shared types and helpers for the Z accumulator writer.
package z_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } z_acc_state_e;

  // Bit patterns of the signed extremes for a given width, taken from the low w bits.
  function automatic logic [63:0] s_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] s_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/z_sat_add.sv
// Combinational signed adder: saturating when Z_ACC_SAT_EN is defined, wrapping otherwise.
module z_sat_add #(
  parameter int W = 16
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);
  import z_pkg::*;

  logic signed [W-1:0] raw;

`ifdef Z_ACC_SAT_EN
  localparam logic [W-1:0] SMAX = W'(s_max(W));
  localparam logic [W-1:0] SMIN = W'(s_min(W));
  logic ovf_raw;

  always_comb begin
    raw     = a + b;
    // Overflow only when both operands share a sign that the result lost.
    ovf_raw = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);
    sum     = ovf_raw ? (a[W-1] ? SMIN : SMAX) : raw;
    ovf     = ovf_raw;
  end
`else
  always_comb begin
    raw = a + b;
    sum = raw;
    ovf = 1'b0;
  end
`endif

endmodule

// File: rtl/z_accum_writer.sv
// Sums num_keys signed products per query and writes each Z_j to the Z memory.
// Z_ACC_SAT_EN selects saturating adds with a sticky sat_flag; default build wraps.
module z_accum_writer import z_pkg::*; #(
  parameter int PROD_WIDTH      = 16,
  parameter int MAX_NUM_QUERIES = 256,
  parameter int ADDR_WIDTH      = $clog2(MAX_NUM_QUERIES),
  parameter int MAX_NUM_KEYS    = 256,
  parameter int KEY_W           = $clog2(MAX_NUM_KEYS) + 1
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          num_queries,
  input  logic [KEY_W-1:0]             num_keys,
  input  logic                         prod_valid,
  output logic                         prod_ready,
  input  logic signed [PROD_WIDTH-1:0] prod_data,
  output logic [ADDR_WIDTH-1:0]        z_addr,
  output logic signed [PROD_WIDTH-1:0] z_wdata,
  output logic                         z_rw_,
  output logic                         busy,
  output logic                         done,
  output logic                         sat_flag,
  output z_acc_state_e                 state_dbg
);

  // Handshake: a product transfers on a rising edge where prod_valid && prod_ready;
  // prod_ready is registered and high only in ACCUM, so prod_data must hold until taken.

  z_acc_state_e state, state_nxt;

  logic [ADDR_WIDTH:0]          nq;
  logic [KEY_W-1:0]             nk;
  logic [KEY_W-1:0]             k_cnt;
  logic [ADDR_WIDTH-1:0]        q_idx;
  logic signed [PROD_WIDTH-1:0] acc;
  logic signed [PROD_WIDTH-1:0] sum;
  logic                         ovf;
  logic                         hs;
  logic                         k_last;
  logic                         q_last;

  logic                         ready_d;
  logic                         busy_d;
  logic                         done_d;
  logic                         rw_d;
  logic [ADDR_WIDTH-1:0]        addr_d;
  logic signed [PROD_WIDTH-1:0] wdata_d;

  z_sat_add #(.W(PROD_WIDTH)) u_add (
    .a   (acc),
    .b   (prod_data),
    .sum (sum),
    .ovf (ovf)
  );

  assign hs        = prod_valid && prod_ready;
  assign k_last    = (k_cnt == nk - KEY_W'(1));
  assign q_last    = ({1'b0, q_idx} == nq - (ADDR_WIDTH + 1)'(1));
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_queries == '0)   state_nxt = DONE;
          else if (num_keys == '0) state_nxt = WRITE;
          else                     state_nxt = ACCUM;
        end
      end
      ACCUM: if (hs && k_last) state_nxt = WRITE;
      WRITE: begin
        if (q_last)          state_nxt = DONE;
        else if (nk == '0)   state_nxt = WRITE;
        else                 state_nxt = ACCUM;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight off a flop.
  always_comb begin
    ready_d = (state_nxt == ACCUM);
    busy_d  = (state_nxt == ACCUM) || (state_nxt == WRITE);
    done_d  = (state_nxt == DONE);
    rw_d    = (state_nxt != WRITE);
    addr_d  = z_addr;
    wdata_d = z_wdata;
    if (state_nxt == WRITE) begin
      case (state)
        IDLE:    addr_d = '0;
        WRITE:   addr_d = q_idx + ADDR_WIDTH'(1);
        default: addr_d = q_idx;
      endcase
      wdata_d = (state == ACCUM) ? sum : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      prod_ready <= 1'b0;
      z_addr     <= '0;
      z_wdata    <= '0;
      z_rw_      <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      sat_flag   <= 1'b0;
      nq         <= '0;
      nk         <= '0;
      k_cnt      <= '0;
      q_idx      <= '0;
      acc        <= '0;
    end else begin
      prod_ready <= ready_d;
      z_addr     <= addr_d;
      z_wdata    <= wdata_d;
      z_rw_      <= rw_d;
      busy       <= busy_d;
      done       <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            nq       <= num_queries;
            nk       <= num_keys;
            acc      <= '0;
            k_cnt    <= '0;
            q_idx    <= '0;
            sat_flag <= 1'b0;
          end
        end
        ACCUM: begin
          if (hs) begin
            acc   <= sum;
            k_cnt <= k_cnt + KEY_W'(1);
            if (ovf) sat_flag <= 1'b1;
          end
        end
        WRITE: begin
          acc   <= '0;
          k_cnt <= '0;
          q_idx <= q_idx + ADDR_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z_accum_writer.sv
// Scoreboard bench for z_accum_writer: expected Z writes queued at stimulus time, checked on write.
module tb_z_accum_writer;
  import z_pkg::*;

  localparam int PW   = 16;
  localparam int AW   = 8;
  localparam int KW   = 9;
  localparam int SMAX = 2 ** (PW - 1) - 1;
  localparam int SMIN = -(2 ** (PW - 1));

  logic          clk = 1'b0;
  logic          rst_ = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_queries = '0;
  logic [KW-1:0] num_keys = '0;
  logic          prod_valid = 1'b0;
  logic          prod_ready;
  logic [PW-1:0] prod_data = '0;
  logic [AW-1:0] z_addr;
  logic [PW-1:0] z_wdata;
  logic          z_rw_;
  logic          busy;
  logic          done;
  logic          sat_flag;
  z_acc_state_e  state_dbg;

  int total = 0;
  int bad = 0;
  int write_cnt = 0;
  bit exp_sat = 1'b0;
  logic [AW+PW-1:0] exp_q[$];
  logic [PW-1:0]    prod_q[$];

  z_accum_writer dut (
    .clk         (clk),
    .rst_        (rst_),
    .start       (start),
    .num_queries (num_queries),
    .num_keys    (num_keys),
    .prod_valid  (prod_valid),
    .prod_ready  (prod_ready),
    .prod_data   (prod_data),
    .z_addr      (z_addr),
    .z_wdata     (z_wdata),
    .z_rw_       (z_rw_),
    .busy        (busy),
    .done        (done),
    .sat_flag    (sat_flag),
    .state_dbg   (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] m_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef Z_ACC_SAT_EN
    if (s > SMAX) begin
      s = SMAX;
      exp_sat = 1'b1;
    end else if (s < SMIN) begin
      s = SMIN;
      exp_sat = 1'b1;
    end
`endif
    return s[PW-1:0];
  endfunction

  task automatic push_p(input int v);
    prod_q.push_back(v[PW-1:0]);
  endtask

  // scoreboard: every write cycle pops one expected {addr, data}
  always @(negedge clk) begin
    if (rst_ && !z_rw_) begin
      write_cnt++;
      check("ready_in_write", prod_ready, 0);
      if (exp_q.size() == 0) check("write_expected", exp_q.size(), 1);
      else check("z_write", {z_addr, z_wdata}, exp_q.pop_front());
    end
  end

  // mode: 0 = valid always high, 1 = toggle 1,0,1,0..., 2 = random
  task automatic run(input int nq, input int nk, input int mode, input bit poke_start);
    logic [PW-1:0] acc;
    int idx = 0;
    int cyc = 0;
    int hs_cnt = 0;
    bit hs;
    bit phase = 1'b1;
    exp_sat   = 1'b0;
    write_cnt = 0;
    for (int q = 0; q < nq; q++) begin
      acc = '0;
      for (int k = 0; k < nk; k++) begin
        acc = m_add(acc, prod_q[idx]);
        idx++;
      end
      exp_q.push_back({q[AW-1:0], acc});
    end
    @(negedge clk);
    start = 1'b1;
    num_queries = nq[AW:0];
    num_keys = nk[KW-1:0];
    @(negedge clk);
    start = 1'b0;
    if (nq != 0) check("busy_run", busy, 1);
    while (!done && cyc < 2000) begin
      prod_valid = (prod_q.size() != 0) && phase;
      prod_data  = (prod_q.size() != 0) ? prod_q[0] : '0;
      hs = prod_valid && prod_ready;
      if (mode == 1) phase = !phase;
      else if (mode == 2) phase = 1'($urandom_range(0, 1));
      @(negedge clk);
      cyc++;
      if (hs) begin
        void'(prod_q.pop_front());
        hs_cnt++;
        if (hs_cnt % nk == 0) check("write_latency", z_rw_, 0);
      end
    end
    prod_valid = 1'b0;
    check("done", done, 1);
    check("busy_at_done", busy, 0);
    if (mode == 0) check("done_cycle", cyc, nq * (nk + 1));
    check("hs_count", hs_cnt, nq * nk);
    check("write_count", write_cnt, nq);
    check("sat_flag", sat_flag, exp_sat);
    check("exp_q_empty", exp_q.size(), 0);
    if (poke_start) begin
      start = 1'b1;
      num_queries = 1;
      num_keys = 0;
    end
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", done, 0);
    check("idle_after", state_dbg, IDLE);
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("rw_idle", z_rw_, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, prod_ready, 0);
    check({tag, "_rw"}, z_rw_, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sat"}, sat_flag, 0);
    check({tag, "_addr"}, z_addr, 0);
    check({tag, "_wdata"}, z_wdata, 0);
    check({tag, "_state"}, state_dbg, IDLE);
  endtask

  initial begin
    int cyc;
    int hs_cnt;
    bit hs;
    @(negedge clk);
    check_reset_values("reset");
    @(negedge clk);
    rst_ = 1'b1;

    // two queries of three products, valid always high
    push_p(1); push_p(2); push_p(3);
    push_p(-4); push_p(5); push_p(6);
    run(2, 3, 0, 1'b0);

    // valid toggling, single query
    push_p(100); push_p(-7); push_p(20); push_p(-300);
    run(1, 4, 1, 1'b0);

    // zero keys: only zero writes
    run(3, 0, 0, 1'b0);

    // zero queries, plus a start during the done cycle
    run(0, 5, 0, 1'b1);

    // overflow at the positive boundary
    push_p(16'h7FFF); push_p(16'h0001);
    run(1, 2, 0, 1'b0);

    // overflow at the negative boundary
    push_p(16'h8000); push_p(-1); push_p(5);
    run(1, 3, 0, 1'b0);

    // random products and random valid
    for (int i = 0; i < 20; i++) push_p(int'($urandom_range(0, 20000)) - 10000);
    run(4, 5, 2, 1'b0);

    // reset in the middle of query 1
    push_p(1); push_p(2); push_p(3);
    push_p(4); push_p(5); push_p(6);
    exp_q.push_back({8'd0, 16'd6});
    write_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    num_queries = 2;
    num_keys = 3;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    hs_cnt = 0;
    while (hs_cnt < 4 && cyc < 100) begin
      prod_valid = (prod_q.size() != 0);
      prod_data  = (prod_q.size() != 0) ? prod_q[0] : '0;
      hs = prod_valid && prod_ready;
      @(negedge clk);
      cyc++;
      if (hs) begin
        void'(prod_q.pop_front());
        hs_cnt++;
      end
    end
    check("pre_reset_hs", hs_cnt, 4);
    check("pre_reset_busy", busy, 1);
    #2;
    rst_ = 1'b0;
    #1;
    check_reset_values("async_rst");
    prod_valid = 1'b0;
    prod_q.delete();
    repeat (3) @(negedge clk);
    check("rw_in_reset", z_rw_, 1);
    check("writes_before_reset", write_cnt, 1);
    check("no_pending_exp", exp_q.size(), 0);
    rst_ = 1'b1;
    push_p(10);
    push_p(-3);
    run(2, 1, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
